mac_pipe: RTL and testbench
===========================

// Module: mac_pipe
// PURPOSE
//  Parametrised, 3-stage pipelined multiply-accumulate unit; next generation of the dadda MAC (a*b + x).
//  Adds valid/ready handshaking with backpressure, an internal accumulator and per-transaction op modes.
//  Sits between the operand source and the result consumer; throughput one op per clock.
// PARAMETERS
//  A_W    8   width of multiplicand a (unsigned)
//  B_W    8   width of multiplier b (unsigned)
//  ACC_W  16  width of addend, result and accumulator; elaboration error if ACC_W < A_W+B_W
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input transaction present
//  in_ready   out  1      unit accepts input this cycle
//  in_a       in   A_W    multiplicand
//  in_b       in   B_W    multiplier
//  in_x       in   ACC_W  external addend (used by MODE_MAC only)
//  in_mode    in   2      mac_pkg::mode_t
//  out_valid  out  1      result present
//  out_ready  in   1      consumer accepts result
//  mult_out   out  ACC_W  result
//  cout       out  1      carry out of final ACC_W-bit add
// BEHAVIOUR
//  Reset (async, rst_n=0): all stage valids=0, out_valid=0, mult_out=0, cout=0, acc=0. in_ready=1 after reset.
//  Stages: S1 registers {a,b,x,mode}; S2 registers {prod=a*b, x, mode}; S3 registers {mult_out, cout}.
//  Transfer: in_valid&&in_ready; out_valid&&out_ready. Stage k loads when empty or its content advances.
//  Ready chain is combinational: in_ready = !v1 | (!v2 | (!v3 | out_ready)). No bubbles, no loss, no duplication.
//  Latency: 3 cycles from input accept to out_valid with out_ready held high.
//  Stall: out_valid=1 && out_ready=0 holds mult_out/cout stable; the pipeline fills to 3 entries, then in_ready=0.
//  Arithmetic: prod zero-extended to ACC_W; sum[ACC_W:0] = prod + addend; mult_out=sum[ACC_W-1:0], cout=sum[ACC_W].
//  Modes (addend select / acc update, both performed on the S2->S3 edge):
//   MODE_MAC   2'b00  addend=x,   acc unchanged
//   MODE_ACC   2'b01  addend=acc, acc<=mult_out
//   MODE_START 2'b10  addend=0,   acc<=mult_out (begins a new accumulation)
//   MODE_MUL   2'b11  addend=0,   acc unchanged
//  The acc update and the S3 load occur on the same edge, so back-to-back MODE_ACC ops need no forwarding or stall.
//  acc never updates while S3 is stalled.
//  Reset mid-operation: in-flight ops are discarded and acc is cleared; no output is produced for them.
// CONFIGURATION
//  MAC_PIPE_SATURATE_EN defined: when cout=1, mult_out = all ones and acc (if updated) loads all ones.
//   cout still reports the overflow.
//  MAC_PIPE_SATURATE_EN undefined: results wrap modulo 2^ACC_W; acc loads the wrapped value.
// STRUCTURE
//  Package mac_pkg: mode_t enum (MODE_MAC, MODE_ACC, MODE_START, MODE_MUL); default width localparams.
//  Sub-module mac_mult_tree #(A_W,B_W): combinational Dadda reduction producing the A_W+B_W-bit product.
//   It sits between S1 and S2.
//  Handshake, mode mux, final adder, saturation and acc live in mac_pipe.
// TESTING (defaults A_W=B_W=8, ACC_W=16)
//  MAC 70*20 + 0x1111, out_ready=1 -> mult_out=0x1689, cout=0, out_valid exactly 3 cycles after accept.
//  MAC 215*200 + 0xFF00 -> wrap build: mult_out=0xA6F8, cout=1; SATURATE build: 0xFFFF, cout=1.
//  MAC 255*255 + 0xFFFF -> wrap build: mult_out=0xFE00, cout=1.
//  START 10*10, ACC 20*20, ACC 3*3 issued back-to-back -> results 0x0064, 0x01F4, 0x01FD on consecutive cycles.
//  Backpressure: 5 MAC ops streamed, out_ready=0 for 6 cycles -> in_ready drops after the 3rd accept.
//   mult_out is held; after release all 5 results arrive in order with none lost.
//  Reset pulse with 2 ops in flight and acc=0x01F4 -> no out_valid for them; next ACC 1*1 yields 0x0001.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared op modes, default widths and Dadda sizing helpers for mac_pipe
package mac_pkg;

  typedef enum logic [1:0] {
    MODE_MAC   = 2'b00,
    MODE_ACC   = 2'b01,
    MODE_START = 2'b10,
    MODE_MUL   = 2'b11
  } mode_t;

  localparam int DEF_A_W   = 8;
  localparam int DEF_B_W   = 8;
  localparam int DEF_ACC_W = 16;

  // Column height of the partial-product matrix, floored at 3 so full-adder taps always exist.
  function automatic int dadda_height(input int a_w, input int b_w);
    int m;
    m = (a_w < b_w) ? a_w : b_w;
    return (m < 3) ? 3 : m;
  endfunction

  // Dadda target heights: d1 = 2, d(k+1) = floor(1.5 * d(k)).
  function automatic int dadda_target(input int k);
    int d;
    d = 2;
    for (int i = 1; i < k; i++) d = (d * 3) / 2;
    return d;
  endfunction

  function automatic int dadda_stages(input int h);
    int n;
    int d;
    n = 0;
    d = 2;
    for (int i = 0; i < 32; i++) begin
      if (d < h) begin
        n++;
        d = (d * 3) / 2;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/mac_pipe_if.sv
// rtl/mac_pipe_if.sv - operand and result handshake bundle for mac_pipe
interface mac_pipe_if
  import mac_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int ACC_W = DEF_ACC_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic [ACC_W-1:0] in_x;
  mode_t            in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] mult_out;
  logic             cout;

  modport master (
    output in_valid, in_a, in_b, in_x, in_mode, out_ready,
    input  in_ready, out_valid, mult_out, cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_x, in_mode, out_ready,
    output in_ready, out_valid, mult_out, cout
  );

endinterface

// File: rtl/mac_mult_tree.sv
// rtl/mac_mult_tree.sv - combinational Dadda-reduced unsigned multiplier a*b
module mac_mult_tree
  import mac_pkg::*;
#(
  parameter int A_W = DEF_A_W,
  parameter int B_W = DEF_B_W
) (
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic [A_W+B_W-1:0] prod
);

  localparam int P_W  = A_W + B_W;
  localparam int H    = dadda_height(A_W, B_W);
  localparam int N_ST = dadda_stages(H);

  logic [P_W-1:0] row0;
  logic [P_W-1:0] row1;

  // Columns are bit-stacks packed from bit 0; one spare column absorbs carries off the top.
  always_comb begin
    logic [H-1:0] cur [P_W+1];
    logic [H-1:0] nxt [P_W+1];
    int           cur_h [P_W+1];
    int           nxt_h [P_W+1];
    logic [H-1:0] win;
    int           idx;
    int           total;
    int           d;
    logic         s_bit;
    logic         c_bit;
    logic         red;

    row0 = '0;
    row1 = '0;
    win  = '0;
    idx  = 0;
    total = 0;
    d    = 0;
    s_bit = 1'b0;
    c_bit = 1'b0;
    red  = 1'b0;
    for (int c = 0; c <= P_W; c++) begin
      cur[c]   = '0;
      nxt[c]   = '0;
      cur_h[c] = 0;
      nxt_h[c] = 0;
    end

    for (int i = 0; i < A_W; i++) begin
      for (int j = 0; j < B_W; j++) begin
        cur[i+j]   = cur[i+j] | (H'(a[i] & b[j]) << cur_h[i+j]);
        cur_h[i+j] = cur_h[i+j] + 1;
      end
    end

    for (int s = N_ST; s >= 1; s--) begin
      d = dadda_target(s);
      for (int c = 0; c <= P_W; c++) begin
        nxt[c]   = '0;
        nxt_h[c] = 0;
      end
      for (int c = 0; c < P_W; c++) begin
        idx   = 0;
        total = cur_h[c] + nxt_h[c];
        for (int k = 0; k < H; k++) begin
          win = cur[c] >> idx;
          red = 1'b0;
          if (total > d && total - d >= 2 && cur_h[c] - idx >= 3) begin
            s_bit = win[0] ^ win[1] ^ win[2];
            c_bit = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);
            idx   = idx + 3;
            total = total - 2;
            red   = 1'b1;
          end else if (total > d && cur_h[c] - idx >= 2) begin
            s_bit = win[0] ^ win[1];
            c_bit = win[0] & win[1];
            idx   = idx + 2;
            total = total - 1;
            red   = 1'b1;
          end
          if (red) begin
            nxt[c]     = nxt[c] | (H'(s_bit) << nxt_h[c]);
            nxt_h[c]   = nxt_h[c] + 1;
            nxt[c+1]   = nxt[c+1] | (H'(c_bit) << nxt_h[c+1]);
            nxt_h[c+1] = nxt_h[c+1] + 1;
          end
        end
        win = cur[c] >> idx;
        for (int k = 0; k < H; k++) begin
          if (k < cur_h[c] - idx) begin
            nxt[c]   = nxt[c] | (H'(win[k]) << nxt_h[c]);
            nxt_h[c] = nxt_h[c] + 1;
          end
        end
      end
      for (int c = 0; c <= P_W; c++) begin
        cur[c]   = nxt[c];
        cur_h[c] = nxt_h[c];
      end
    end

    for (int c = 0; c < P_W; c++) begin
      row0[c] = cur[c][0];
      row1[c] = cur[c][1];
    end
  end

  assign prod = row0 + row1;

endmodule

// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - 3-stage valid/ready multiply-accumulate with internal accumulator
// Optional build macro: MAC_PIPE_SATURATE_EN clamps overflowing results to all ones.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic       clk,
  input  logic       rst_n,
  mac_pipe_if.slave  bus
);

  localparam int P_W = A_W + B_W;

  if (ACC_W < P_W) begin : g_bad_width
    $error("mac_pipe: ACC_W must be at least A_W+B_W");
  end

  logic             v1, v2, v3;
  logic             rdy1, rdy2, rdy3;
  logic [A_W-1:0]   a1;
  logic [B_W-1:0]   b1;
  logic [ACC_W-1:0] x1, x2;
  mode_t            m1, m2;
  logic [P_W-1:0]   prod_c, prod2;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] addend;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] res_c, res3;
  logic             cout_c, cout3;

  assign rdy3 = !v3 || bus.out_ready;
  assign rdy2 = !v2 || rdy3;
  assign rdy1 = !v1 || rdy2;

  assign bus.in_ready  = rdy1;
  assign bus.out_valid = v3;
  assign bus.mult_out  = res3;
  assign bus.cout      = cout3;

  mac_mult_tree #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_mult_tree (
    .a    (a1),
    .b    (b1),
    .prod (prod_c)
  );

  always_comb begin
    addend = '0;
    case (m2)
      MODE_MAC: addend = x2;
      MODE_ACC: addend = acc;
      default:  addend = '0;
    endcase
  end

  assign sum    = (ACC_W+1)'(prod2) + (ACC_W+1)'(addend);
  assign cout_c = sum[ACC_W];

`ifdef MAC_PIPE_SATURATE_EN
  assign res_c = cout_c ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign res_c = sum[ACC_W-1:0];
`endif

  // acc is written on the same edge S3 loads, so a following MODE_ACC in S2 already sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      a1    <= '0;
      b1    <= '0;
      x1    <= '0;
      m1    <= MODE_MAC;
      prod2 <= '0;
      x2    <= '0;
      m2    <= MODE_MAC;
      res3  <= '0;
      cout3 <= 1'b0;
      acc   <= '0;
    end else begin
      if (rdy1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          a1 <= bus.in_a;
          b1 <= bus.in_b;
          x1 <= bus.in_x;
          m1 <= bus.in_mode;
        end
      end
      if (rdy2) begin
        v2 <= v1;
        if (v1) begin
          prod2 <= prod_c;
          x2    <= x1;
          m2    <= m1;
        end
      end
      if (rdy3) begin
        v3 <= v2;
        if (v2) begin
          res3  <= res_c;
          cout3 <= cout_c;
          if (m2 == MODE_ACC || m2 == MODE_START) acc <= res_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
// tb/tb_mac_pipe.sv - randomized self-checking bench for mac_pipe against an arithmetic reference model
module tb_mac_pipe;
  import mac_pkg::*;

  localparam int A_W   = 8;
  localparam int B_W   = 8;
  localparam int ACC_W = 16;

`ifdef MAC_PIPE_SATURATE_EN
  localparam logic [15:0] EXP_OVF1 = 16'hFFFF;
  localparam logic [15:0] EXP_OVF2 = 16'hFFFF;
`else
  localparam logic [15:0] EXP_OVF1 = 16'hA6F8;
  localparam logic [15:0] EXP_OVF2 = 16'hFE00;
`endif

  typedef struct packed {
    logic        c;
    logic [15:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac_pipe_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) bus ();

  mac_pipe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          model_acc = 0;
  exp_t        exp_q[$];
  int          log_cyc[$];
  logic [15:0] log_res[$];
  logic        log_cout[$];
  bit          last_acc_fire = 1'b0;
  bit          last_out_fire = 1'b0;
  logic        last_in_ready;
  logic        last_out_valid;
  logic [15:0] last_mult;
  int          acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: ops complete strictly in accept order, so the result is fixed at accept time.
  task automatic model_push(input int m, input int a, input int b, input int x);
    exp_t e;
    int   addend;
    int   sum;
    case (m)
      0:       addend = x;
      1:       addend = model_acc;
      default: addend = 0;
    endcase
    sum = a * b + addend;
    e.c = (sum >= 65536);
    e.r = 16'(sum % 65536);
`ifdef MAC_PIPE_SATURATE_EN
    if (e.c) e.r = 16'hFFFF;
`endif
    if (m == 1 || m == 2) model_acc = int'(e.r);
    exp_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    last_in_ready  = bus.in_ready;
    last_out_valid = bus.out_valid;
    last_mult      = bus.mult_out;
    last_acc_fire  = bus.in_valid && bus.in_ready;
    last_out_fire  = bus.out_valid && bus.out_ready;
    if (last_out_fire) begin
      log_cyc.push_back(cyc);
      log_res.push_back(bus.mult_out);
      log_cout.push_back(bus.cout);
      if (exp_q.size() == 0) begin
        check("out_with_no_pending_op", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("result", {15'b0, bus.cout, bus.mult_out}, {15'b0, e.c, e.r});
      end
    end
    if (last_acc_fire) begin
      acc_cyc = cyc;
      model_push(int'(bus.in_mode), int'(bus.in_a), int'(bus.in_b), int'(bus.in_x));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_res.delete();
    log_cout.delete();
  endtask

  task automatic send_op(input int m, input int a, input int b, input int x);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode_t'(m[1:0]);
    bus.in_a     = 8'(a);
    bus.in_b     = 8'(b);
    bus.in_x     = 16'(x);
    for (int i = 0; i < 50; i++) begin
      step();
      if (last_acc_fire) break;
    end
    check("send_accepted", 32'(last_acc_fire), 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t_acc;
    int          i_op;
    int          n_acc_r;
    logic [15:0] held;
    logic [7:0]  bp_a [5];
    logic [7:0]  bp_b [5];
    logic [15:0] bp_x [5];

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_x      = '0;
    bus.in_mode   = MODE_MAC;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    held          = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_mult_out", 32'(bus.mult_out), 0);
    check("rst_cout", 32'(bus.cout), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Plain MAC and its latency
    clear_log();
    send_op(0, 70, 20, 'h1111);
    t_acc = acc_cyc;
    drain();
    check("mac_count", 32'(log_res.size()), 1);
    if (log_res.size() >= 1) begin
      check("mac_value", 32'(log_res[0]), 32'h1689);
      check("mac_cout", 32'(log_cout[0]), 0);
      check("mac_latency", 32'(log_cyc[0] - t_acc), 3);
    end

    // Overflow cases
    clear_log();
    send_op(0, 215, 200, 'hFF00);
    send_op(0, 255, 255, 'hFFFF);
    drain();
    check("ovf_count", 32'(log_res.size()), 2);
    if (log_res.size() >= 2) begin
      check("ovf1_value", 32'(log_res[0]), 32'(EXP_OVF1));
      check("ovf1_cout", 32'(log_cout[0]), 1);
      check("ovf2_value", 32'(log_res[1]), 32'(EXP_OVF2));
      check("ovf2_cout", 32'(log_cout[1]), 1);
    end

    // Back-to-back accumulation chain
    clear_log();
    send_op(2, 10, 10, 0);
    send_op(1, 20, 20, 0);
    send_op(1, 3, 3, 0);
    drain();
    check("acc_count", 32'(log_res.size()), 3);
    if (log_res.size() >= 3) begin
      check("acc_r0", 32'(log_res[0]), 32'h0064);
      check("acc_r1", 32'(log_res[1]), 32'h01F4);
      check("acc_r2", 32'(log_res[2]), 32'h01FD);
      check("acc_consecutive_a", 32'(log_cyc[1] - log_cyc[0]), 1);
      check("acc_consecutive_b", 32'(log_cyc[2] - log_cyc[1]), 1);
    end

    // Backpressure: 5 ops against a stalled consumer
    for (int k = 0; k < 5; k++) begin
      bp_a[k] = 8'($urandom_range(0, 255));
      bp_b[k] = 8'($urandom_range(0, 255));
      bp_x[k] = 16'($urandom_range(0, 65535));
    end
    clear_log();
    bus.out_ready = 1'b0;
    bus.in_mode   = MODE_MAC;
    i_op = 0;
    for (int k = 0; k < 6; k++) begin
      if (i_op < 5) begin
        bus.in_valid = 1'b1;
        bus.in_a = bp_a[i_op];
        bus.in_b = bp_b[i_op];
        bus.in_x = bp_x[i_op];
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (last_acc_fire) i_op++;
      if (k == 3) begin
        held = last_mult;
        check("stall_head", 32'(held), 32'(exp_q[0].r));
      end
      if (k == 5) begin
        check("stall_hold", 32'(last_mult), 32'(held));
        check("stall_valid", 32'(last_out_valid), 1);
      end
    end
    check("bp_accepts", 32'(i_op), 3);
    check("bp_in_ready", 32'(last_in_ready), 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (i_op >= 5) break;
      bus.in_valid = 1'b1;
      bus.in_a = bp_a[i_op];
      bus.in_b = bp_b[i_op];
      bus.in_x = bp_x[i_op];
      step();
      if (last_acc_fire) i_op++;
    end
    drain();
    check("bp_count", 32'(log_res.size()), 5);

    // Reset with ops in flight
    clear_log();
    send_op(2, 10, 10, 0);
    send_op(1, 20, 20, 0);
    drain();
    if (log_res.size() >= 2) check("pre_rst_acc", 32'(log_res[1]), 32'h01F4);
    send_op(0, 12, 34, 'h0055);
    send_op(0, 56, 78, 'h0066);
    rst_n = 1'b0;
    exp_q.delete();
    model_acc = 0;
    clear_log();
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("rst_no_output", 32'(log_res.size()), 0);
    send_op(1, 1, 1, 0);
    drain();
    check("post_rst_count", 32'(log_res.size()), 1);
    if (log_res.size() >= 1) check("post_rst_acc", 32'(log_res[0]), 32'h0001);

    // Random traffic with random backpressure
    clear_log();
    n_acc_r = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(bus.in_valid && !last_acc_fire)) begin
        if ($urandom_range(0, 3) != 0) begin
          bus.in_valid = 1'b1;
          bus.in_a     = 8'($urandom_range(0, 255));
          bus.in_b     = 8'($urandom_range(0, 255));
          bus.in_x     = 16'($urandom_range(0, 65535));
          bus.in_mode  = mode_t'(2'($urandom_range(0, 3)));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
      if (last_acc_fire) n_acc_r++;
    end
    drain();
    check("rand_count", 32'(log_res.size()), 32'(n_acc_r));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
